// File: rtl/ps2_key_receiver_pkg.sv
// Shared types and constants for the PS/2 key receiver.
package ps2_defs;

  // Frame reception states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam int unsigned ENTRY_W = 10;

  // One key event as stored in the event FIFO.
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;

  // True when the data byte plus its parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_key_receiver_fifo.sv
// Show-ahead key-event FIFO with extra-MSB pointers and overflow pulse.
module ps2_event_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic             overflow_q;

  logic empty_c;
  logic full_c;
  logic do_pop_c;
  logic do_push_c;

  assign empty_c   = (wr_ptr_q == rd_ptr_q);
  assign full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop_c  = pop_i && !empty_c;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push_c = push_i && (!full_c || do_pop_c);

  assign valid_o    = !empty_c;
  assign rd_data_o  = empty_c ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign overflow_o = overflow_q;

  // Storage array; contents are only observable through valid entries.
  always_ff @(posedge Clock) begin
    if (do_push_c) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  // Pointer update and overflow pulse.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push_i && !do_push_c;
      if (do_push_c) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop_c) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronize, filter, deframe, decode prefixes, queue events.
module ps2_key_receiver
  import ps2_defs::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iPS2Clk,
  input  logic       iPS2Data,
  input  logic       iReady,
  output logic       oValid,
  output logic [7:0] oScanCode,
  output logic       oBreak,
  output logic       oExtended,
  output logic       oFrameError,
  output logic       oOverflow
);

  localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  // Synchronizer and filter state.
  logic              clk_s1_q;
  logic              clk_s2_q;
  logic              dat_s1_q;
  logic              dat_s2_q;
  logic              filt_q;
  logic              filt_d;
  logic [FCNT_W-1:0] fcnt_q;
  logic [FCNT_W-1:0] fcnt_d;
  logic              sample_c;

  // Frame state.
  ps2_state_e        state_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic              parity_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              ext_q;
  logic              brk_q;
  logic              push_q;
  ps2_entry_t        entry_q;
  logic              frame_err_q;

  ps2_entry_t        head_c;
  logic              fifo_valid_c;
  logic              fifo_ovf_c;

  // Two-flop synchronizers; idle level of the PS/2 lines is high.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= iPS2Clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= iPS2Data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Glitch filter: follow the synchronized clock only after FILTER_LEN differing samples in a row.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
  end

  // Filter registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  // The falling edge of the filtered clock is the bit-sample point.
  assign sample_c = filt_q && !filt_d;

  // Frame FSM with timeout, prefix decoding and registered push/error outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      push_q      <= 1'b0;
      entry_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      if (state_q != ST_IDLE && !sample_c) begin
        if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // Keyboard went quiet mid-frame: drop the partial byte.
          state_q     <= ST_IDLE;
          to_cnt_q    <= '0;
          frame_err_q <= 1'b1;
          ext_q       <= 1'b0;
          brk_q       <= 1'b0;
        end else begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
        end
      end else begin
        to_cnt_q <= '0;
        if (sample_c) begin
          case (state_q)
            ST_IDLE: begin
              if (!dat_s2_q) begin
                state_q   <= ST_DATA;
                bit_cnt_q <= '0;
              end
            end
            ST_DATA: begin
              shift_q   <= {dat_s2_q, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q <= ST_PARITY;
              end
            end
            ST_PARITY: begin
              parity_q <= dat_s2_q;
              state_q  <= ST_STOP;
            end
            ST_STOP: begin
              state_q <= ST_IDLE;
              if (dat_s2_q && odd_parity_ok(shift_q, parity_q)) begin
                if (shift_q == SC_EXT) begin
                  ext_q <= 1'b1;
                end else if (shift_q == SC_BREAK) begin
                  brk_q <= 1'b1;
                end else begin
                  push_q       <= 1'b1;
                  entry_q.ext  <= ext_q;
                  entry_q.brk  <= brk_q;
                  entry_q.code <= shift_q;
                  ext_q        <= 1'b0;
                  brk_q        <= 1'b0;
                end
              end else begin
                frame_err_q <= 1'b1;
                ext_q       <= 1'b0;
                brk_q       <= 1'b0;
              end
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

  ps2_event_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clock      (Clock),
    .Reset      (Reset),
    .push_i     (push_q),
    .wr_data_i  (entry_q),
    .pop_i      (iReady),
    .valid_o    (fifo_valid_c),
    .rd_data_o  (head_c),
    .overflow_o (fifo_ovf_c)
  );

  // FIFO zeroes its head when empty, so these fields read 0 whenever oValid is low.
  assign oValid      = fifo_valid_c;
  assign oScanCode   = head_c.code;
  assign oBreak      = head_c.brk;
  assign oExtended   = head_c.ext;
  assign oFrameError = frame_err_q;
  assign oOverflow   = fifo_ovf_c;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Scoreboard bench for ps2_key_receiver: frame driver, key-event model, decoupled monitor.
module tb_ps2_key_receiver;
  import ps2_defs::*;

  localparam int unsigned FLT   = 4;
  localparam int unsigned TO    = 200;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned HALF  = 20;

  logic       Clock    = 1'b0;
  logic       Reset    = 1'b1;
  logic       iPS2Clk  = 1'b1;
  logic       iPS2Data = 1'b1;
  logic       iReady   = 1'b0;
  logic       oValid;
  logic [7:0] oScanCode;
  logic       oBreak;
  logic       oExtended;
  logic       oFrameError;
  logic       oOverflow;

  ps2_key_receiver #(
    .FILTER_LEN     (FLT),
    .TIMEOUT_CYCLES (TO),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .iPS2Clk     (iPS2Clk),
    .iPS2Data    (iPS2Data),
    .iReady      (iReady),
    .oValid      (oValid),
    .oScanCode   (oScanCode),
    .oBreak      (oBreak),
    .oExtended   (oExtended),
    .oFrameError (oFrameError),
    .oOverflow   (oOverflow)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   m_ext = 0;
  bit   m_brk = 0;
  int   exp_err = 0;
  int   exp_ovf = 0;
  int   seen_err = 0;
  int   seen_ovf = 0;
  int   pop_cnt = 0;
  bit   rand_ready = 0;
  bit   ready_fixed = 1;

  task automatic wait_clks(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model of one received frame: keyboard prefix rules and FIFO capacity.
  task automatic model_frame(input logic [7:0] b, input bit good);
    exp_t e;
    if (!good) begin
      exp_err++;
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      e.code = b;
      e.brk  = m_brk;
      e.ext  = m_ext;
      if (exp_q.size() >= DEPTH) exp_ovf++;
      else exp_q.push_back(e);
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic ps2_bit(input logic b);
    iPS2Data = b;
    wait_clks(HALF);
    iPS2Clk = 1'b0;
    wait_clks(HALF);
    iPS2Clk = 1'b1;
  endtask

  // Drive the first nbits of a frame (start, 8 data LSB first, parity, stop).
  task automatic send_frame(input logic [7:0] b, input bit bad_parity, input int nbits);
    logic [10:0] fr;
    fr[0]   = 1'b0;
    fr[8:1] = b;
    fr[9]   = (~^b) ^ bad_parity;
    fr[10]  = 1'b1;
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
    iPS2Data = 1'b1;
    wait_clks(HALF);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_parity);
    model_frame(b, !bad_parity);
    send_frame(b, bad_parity, 11);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      wait_clks(1);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_pulses(input string name);
    check({name, "_frame_err"}, seen_err, exp_err);
    check({name, "_overflow"}, seen_ovf, exp_ovf);
  endtask

  // Consumer handshake driver.
  initial begin
    forever begin
      @(posedge Clock);
      #1;
      iReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'(ready_fixed);
    end
  end

  // Monitor: pops the scoreboard on every accepted head entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        if (oFrameError) seen_err++;
        if (oOverflow) seen_ovf++;
        if (oValid && iReady) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_entry got code=%h brk=%b ext=%b expected none",
                     oScanCode, oBreak, oExtended);
          end else begin
            e = exp_q.pop_front();
            pop_cnt++;
            if (oScanCode !== e.code || oBreak !== e.brk || oExtended !== e.ext) begin
              failures++;
              $display("FAIL entry got code=%h brk=%b ext=%b expected code=%h brk=%b ext=%b",
                       oScanCode, oBreak, oExtended, e.code, e.brk, e.ext);
            end
          end
        end else if (!oValid) begin
          checks++;
          if ({oScanCode, oBreak, oExtended} !== 10'd0) begin
            failures++;
            $display("FAIL idle_fields got code=%h brk=%b ext=%b expected 0",
                     oScanCode, oBreak, oExtended);
          end
        end
      end
    end
  end

  // Watchdog keeps the run bounded.
  initial begin
    #800000;
    failures++;
    $display("FAIL watchdog got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int p0;
    logic [7:0] b;
    int r;

    // Reset state
    wait_clks(3);
    check("reset_outputs", {oValid, oScanCode, oBreak, oExtended, oFrameError, oOverflow}, 0);
    Reset = 1'b0;
    wait_clks(5);
    check("post_reset_valid", oValid, 0);

    // Plain make code
    ready_fixed = 1;
    send_byte(8'h1C, 0);
    drain("make_1c_drain");
    check("make_1c_pops", pop_cnt, 1);
    check_pulses("make_1c");

    // Extended release
    p0 = pop_cnt;
    send_byte(8'hE0, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h6B, 0);
    drain("ext_break_drain");
    check("ext_break_pops", pop_cnt - p0, 1);
    check_pulses("ext_break");

    // Parity error then good frame
    p0 = pop_cnt;
    send_byte(8'h1C, 1);
    send_byte(8'h32, 0);
    drain("parity_drain");
    check("parity_pops", pop_cnt - p0, 1);
    check_pulses("parity");

    // Timeout after 4 data bits
    p0 = pop_cnt;
    exp_err++;
    m_ext = 0;
    m_brk = 0;
    send_frame(8'h5A, 0, 5);
    wait_clks(TO + 50);
    send_byte(8'h29, 0);
    drain("timeout_drain");
    check("timeout_pops", pop_cnt - p0, 1);
    check_pulses("timeout");

    // Overflow with consumer stalled
    p0 = pop_cnt;
    ready_fixed = 0;
    wait_clks(2);
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 0);
    wait_clks(10);
    check("ovf_valid_held", oValid, 1);
    check("ovf_no_pops", pop_cnt - p0, 0);
    check_pulses("overflow");
    ready_fixed = 1;
    drain("ovf_drain");
    check("ovf_pops", pop_cnt - p0, 4);

    // Reset mid-frame discards frame and queued entries
    p0 = pop_cnt;
    ready_fixed = 0;
    wait_clks(2);
    send_byte(8'h15, 0);
    check("pre_reset_valid", oValid, 1);
    send_frame(8'h77, 0, 5);
    Reset = 1'b1;
    #1;
    check("reset_mid_outputs", {oValid, oScanCode, oBreak, oExtended, oFrameError, oOverflow}, 0);
    exp_q.delete();
    m_ext = 0;
    m_brk = 0;
    wait_clks(3);
    Reset = 1'b0;
    ready_fixed = 1;
    wait_clks(2 * HALF);
    check("post_reset_no_entry", oValid, 0);
    send_byte(8'h1D, 0);
    drain("reset_1d_drain");
    check("reset_1d_pops", pop_cnt - p0, 1);
    check_pulses("reset");

    // Randomized key stream with random consumer stalls
    rand_ready = 1;
    for (int k = 0; k < 24; k++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) send_byte(8'hE0, 0);
      if (r <= 1) send_byte(8'hF0, 0);
      b = 8'($urandom);
      send_byte(b, $urandom_range(0, 7) == 0);
    end
    rand_ready = 0;
    ready_fixed = 1;
    drain("random_drain");
    check_pulses("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
